// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - receiver FSM encodings and frame constants
package uart_rx_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    localparam logic [2:0] LAST_BIT = 3'd7;

endpackage

// File: rtl/baudgen.vh
// rtl/baudgen.vh - shared baud divisors in clock cycles per bit
`ifndef BAUDGEN_VH
`define BAUDGEN_VH

`define B115200 104
`define B57600  208
`define B38400  313
`define B19200  625
`define B9600   1250
`define B4800   2500
`define B2400   5000
`define B1200   10000
`define B600    20000
`define B300    40000

`endif

// File: rtl/baudgen_rx.sv
// rtl/baudgen_rx.sv - bit-timing counter: half-period tick first, full-period ticks after
module baudgen_rx #(
    parameter int BAUD = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (BAUD > 1) ? $clog2(BAUD) : 1;
    localparam logic [W-1:0] HALF    = W'(BAUD / 2);
    localparam logic [W-1:0] FULL_M1 = W'(BAUD - 1);

    logic [W-1:0] cnt;
    logic         first;

    assign tick = en && (cnt == (first ? HALF : FULL_M1));

    // Clearing re-arms the half-period so the first tick lands mid start bit.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt   <= '0;
            first <= 1'b1;
        end else if (en) begin
            if (tick) begin
                cnt   <= '0;
                first <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with framing-error detection
`include "baudgen.vh"

module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUD = `B115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv,
    output logic       ferr
);

    logic       rx_m;
    logic       rx_s;
    logic [2:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] sr;
    logic       tick;
    logic       en;
    logic       clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign en  = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
    assign clr = !en;

    baudgen_rx #(
        .BAUD (BAUD)
    ) u_baudgen (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (clr),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= 3'd0;
            sr      <= 8'h00;
            data    <= 8'h00;
            rcv     <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            rcv  <= 1'b0;
            ferr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state   <= ST_START;
                        bit_cnt <= 3'd0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state <= rx_s ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        sr <= {rx_s, sr[7:1]};
                        if (bit_cnt == LAST_BIT) begin
                            state <= ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (rx_s) begin
                            data  <= sr;
                            rcv   <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            ferr  <= 1'b1;
                            state <= ST_WAIT_HIGH;
                        end
                    end
                end
                // A held-low break parks here so it reports only one ferr.
                ST_WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUD, default `B115200 from baudgen.vh; clock cycles per bit.
REQ-002 SHALL have port clk, input, 1, system clock; the only clock.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port rx, input, 1, asynchronous serial line; idles high.
REQ-005 SHALL have port data, output, 8, last correctly framed byte received.
REQ-006 SHALL have port rcv, output, 1, one-cycle pulse when data is updated.
REQ-007 SHALL have port ferr, output, 1, one-cycle pulse on a frame with a bad stop bit.

Function
REQ-008 SHALL pass rx through a two-flop synchronizer (rx_s) before any other use; all timing below counts from rx_s.
REQ-009 SHALL use an FSM with states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-010 IDLE: when rx_s==0, go to START and clear the bit counter.
REQ-011 START: after BAUD/2 cycles (integer division), sample rx_s; if 0 go to DATA, if 1 (glitch) go to IDLE with no output pulse.
REQ-012 DATA: sample rx_s every BAUD cycles; shift 8 bits LSB first into a shift register; go to STOP after the 8th sample.
REQ-013 STOP: sample rx_s BAUD cycles after the 8th data sample.
- If 1: load data from the shift register, pulse rcv for one cycle, go to IDLE.
- If 0: pulse ferr for one cycle, leave data unchanged, go to WAIT_HIGH.
REQ-014 WAIT_HIGH: stay until rx_s==1, then go to IDLE; a held-low break SHALL yield exactly one ferr.
REQ-015 rcv/ferr SHALL assert the cycle after the stop sample, i.e. BAUD/2 + 9*BAUD + 1 cycles after IDLE sees rx_s==0.
REQ-016 SHALL hold data stable between rcv pulses; rcv and ferr SHALL never assert together.
REQ-017 A start edge in IDLE the cycle after a STOP->IDLE transition SHALL be accepted, so back-to-back frames with 1 stop bit lose no byte.
REQ-018 The bit-timing counter SHALL be sized by $clog2(BAUD) and SHALL restart at each state entry; no free-running baud tick.
REQ-019 Only 8N1 framing is supported; no parity.

Reset
REQ-020 On rst==1 at a clk edge: state=IDLE, data=8'h00, rcv=0, ferr=0, counters cleared, synchronizer flops=1.
REQ-021 Reset mid-frame SHALL abandon the frame with no pulse; reception resumes on the next falling edge after rst deasserts.

Structure
REQ-022 Baud divisor constants (`B115200 ... `B300) SHALL stay in the shared baudgen.vh header; no new constants are added there.
REQ-023 SHALL use one sub-module, baudgen_rx: a BAUD-period counter with enable and clear inputs and an output pulse at half period for the first bit and full period for later bits; uart_rx owns the FSM.

Verification (BAUD=`B115200=104, clk period 2 units; scenarios 1-5 REQ-024..REQ-028, 6 REQ-029)
REQ-024 Drive frame 0x55 -> exactly one rcv pulse, data=8'h55, ferr never high.
REQ-025 Drive 0x00 then 0xFF back-to-back with one stop bit each -> two rcv pulses, data 8'h00 then 8'hFF.
REQ-026 Drive rx low for 20 cycles in idle, then high -> no rcv, no ferr, FSM back in IDLE.
REQ-027 Drive 0xA3 with stop bit 0, line held low 3*BAUD -> one ferr pulse, data keeps its previous value, no rcv; next good frame 0x3C -> rcv, data=8'h3C.
REQ-028 Assert rst during bit 4 of a frame -> data=8'h00, no pulse; then frame 0x41 -> rcv, data=8'h41.
REQ-029 Latency check: rcv rises exactly BAUD/2+9*BAUD+3 cycles after the rx falling edge (2 cycles of synchronizer delay plus REQ-015).
